// File: rtl/oled_spi_receiver.sv
// SPI mode-0 receiver for the OLED link: synchronises the raw SPI pins,
// rebuilds D/C-tagged bytes and queues them in a small valid/ready FIFO.
//
// state | meaning
// IDLE  | chip select released, SPI clock edges ignored
// SHIFT | chip select asserted, shifting bits in MSB first
module oled_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        oled_dc,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, dc_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s, mosi_s, dc_s;
  logic                   cs_fall, cs_rise, sclk_rise;

  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       bit_clr, bit_shift, push_req, err_nxt;
  logic [8:0] push_data;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    last_rd;
  logic          full, pop, push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], oled_dc};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // CS release wins over a coincident SCLK edge so a closing frame never pushes.
  always_comb begin
    state_nxt = state;
    bit_clr   = 1'b0;
    bit_shift = 1'b0;
    push_req  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          bit_clr   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          bit_clr   = 1'b1;
          err_nxt   = (bit_cnt != 3'd0);
        end else if (sclk_rise) begin
          bit_shift = 1'b1;
          push_req  = (bit_cnt == 3'd7);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (bit_clr) begin
      bit_cnt   <= '0;
    end else if (bit_shift) begin
      shift_reg <= {shift_reg[6:0], mosi_s};
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  assign push_data = {dc_s, shift_reg[6:0], mosi_s};
  assign rx_valid  = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = rx_valid && rx_ready;
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_rd    <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
    end else begin
      frame_err <= err_nxt;
      if (push_ok) begin
        wr_ptr     <= wr_ptr + 1'b1;
        byte_count <= byte_count + 16'd1;
      end
      if (push_req && !push_ok) overflow <= 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_rd <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO keeps presenting the most recently consumed entry.
  assign rx_data = rx_valid ? mem[rd_ptr][7:0] : last_rd[7:0];
  assign rx_dc   = rx_valid ? mem[rd_ptr][8]   : last_rd[8];

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Scoreboard bench for oled_spi_receiver: SPI frames are bit-banged from tasks
// and every consumed FIFO entry is compared against the queue of expected bytes.
module tb_oled_spi_receiver;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        oled_dc = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_dc;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        overflow;
  logic        frame_err;
  logic [15:0] byte_count;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int fe_cycles = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_item;

  oled_spi_receiver #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .oled_dc(oled_dc), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overflow(overflow),
    .frame_err(frame_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next posedge samples.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (frame_err) fe_cycles++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got dc=%0b data=0x%02h, required no output", rx_dc, rx_data);
        end else begin
          exp_item = exp_q.pop_front();
          if ({rx_dc, rx_data} !== exp_item) begin
            errors++;
            $display("FAIL scoreboard: got dc=%0b data=0x%02h, required dc=%0b data=0x%02h",
                     rx_dc, rx_data, exp_item[8], exp_item[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; oled_dc = 1'b0; rx_ready = 1'b0;
    exp_q.delete();
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_high();
    wait_cyc(HALF);
    spi_cs = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic spi_byte(input logic [7:0] d, input logic dc, input bit exp,
                          input bit pop_last, input int nbits);
    if (exp) exp_q.push_back({dc, d});
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = d[i];
      oled_dc  = dc;
      wait_cyc(HALF);
      spi_clk = 1'b1;
      if (pop_last && i == 0) begin
        wait_cyc(2);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 200) begin
      wait_cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected bytes left, rx_valid=%0b, required 0 and 0",
               name, exp_q.size(), rx_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: data=0x%02h dc=%0b valid=%0b ovf=%0b ferr=%0b cnt=%0d, required all 0",
               rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count);
    end
  endtask

  task automatic test_single_byte();
    int v0;
    do_reset();
    rx_ready = 1'b1;
    v0 = valid_cycles;
    fe_cycles = 0;
    cs_low();
    spi_byte(8'h68, 1'b1, 1'b1, 1'b0, 8);
    cs_high();
    wait_drain("single");
    checks++;
    if (valid_cycles - v0 != 1) begin
      errors++;
      $display("FAIL single_valid_cycles: got %0d, required 1", valid_cycles - v0);
    end
    checks++;
    if (byte_count !== 16'd1) begin
      errors++;
      $display("FAIL single_byte_count: got %0d, required 1", byte_count);
    end
    checks++;
    if (overflow !== 1'b0 || fe_cycles != 0) begin
      errors++;
      $display("FAIL single_flags: overflow=%0b frame_err_cycles=%0d, required 0 and 0", overflow, fe_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cs_low();
    spi_byte(8'hAF, 1'b0, 1'b1, 1'b0, 8);
    spi_byte(8'h65, 1'b1, 1'b1, 1'b0, 8);
    cs_high();
    checks++;
    if (rx_valid !== 1'b1 || byte_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_held: rx_valid=%0b byte_count=%0d, required 1 and 2", rx_valid, byte_count);
    end
    rx_ready = 1'b1;
    wait_drain("b2b");
  endtask

  task automatic test_overflow();
    do_reset();
    cs_low();
    for (int k = 1; k <= 5; k++)
      spi_byte(8'(k), 1'b1, k <= 4, 1'b0, 8);
    cs_high();
    checks++;
    if (overflow !== 1'b1 || byte_count !== 16'd4) begin
      errors++;
      $display("FAIL ovf_flags: overflow=%0b byte_count=%0d, required 1 and 4", overflow, byte_count);
    end
    rx_ready = 1'b1;
    wait_drain("ovf");
    checks++;
    if (rx_data !== 8'h04 || rx_dc !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold_last: data=0x%02h dc=%0b overflow=%0b, required 0x04 1 1", rx_data, rx_dc, overflow);
    end
  endtask

  task automatic test_frame_error();
    do_reset();
    fe_cycles = 0;
    cs_low();
    spi_byte(8'hB3, 1'b1, 1'b0, 1'b0, 5);
    cs_high();
    checks++;
    if (fe_cycles != 1 || byte_count !== 16'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ferr_partial: pulses=%0d byte_count=%0d rx_valid=%0b, required 1 0 0",
               fe_cycles, byte_count, rx_valid);
    end
    rx_ready = 1'b1;
    cs_low();
    spi_byte(8'h6C, 1'b0, 1'b1, 1'b0, 8);
    cs_high();
    wait_drain("ferr");
    checks++;
    if (fe_cycles != 1 || byte_count !== 16'd1) begin
      errors++;
      $display("FAIL ferr_recover: pulses=%0d byte_count=%0d, required 1 and 1", fe_cycles, byte_count);
    end
  endtask

  task automatic test_idle_and_reset();
    int v0;
    do_reset();
    v0 = valid_cycles;
    for (int k = 0; k < 16; k++) begin
      spi_mosi = k[0];
      wait_cyc(HALF); spi_clk = 1'b1;
      wait_cyc(HALF); spi_clk = 1'b0;
    end
    wait_cyc(HALF);
    checks++;
    if (valid_cycles != v0 || byte_count !== 16'd0) begin
      errors++;
      $display("FAIL idle_clocks: valid_cycles=%0d byte_count=%0d, required 0 and 0", valid_cycles - v0, byte_count);
    end
    cs_low();
    spi_byte(8'h5A, 1'b1, 1'b0, 1'b0, 8);
    spi_byte(8'hE0, 1'b1, 1'b0, 1'b0, 3);
    spi_mosi = 1'b1;
    wait_cyc(HALF);
    spi_clk = 1'b1;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    checks++;
    if ({rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count} !== 28'd0) begin
      errors++;
      $display("FAIL midframe_reset: data=0x%02h dc=%0b valid=%0b ovf=%0b ferr=%0b cnt=%0d, required all 0",
               rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count);
    end
    fe_cycles = 0;
    wait_cyc(HALF);
    spi_clk = 1'b0;
    cs_high();
    rx_ready = 1'b1;
    cs_low();
    spi_byte(8'h6F, 1'b1, 1'b1, 1'b0, 8);
    cs_high();
    wait_drain("post_reset");
    checks++;
    if (byte_count !== 16'd1 || fe_cycles != 0) begin
      errors++;
      $display("FAIL post_reset_count: byte_count=%0d frame_err_cycles=%0d, required 1 and 0", byte_count, fe_cycles);
    end
  endtask

  task automatic test_full_with_pop();
    do_reset();
    cs_low();
    for (int k = 1; k <= 4; k++)
      spi_byte(8'(k), 1'b0, 1'b1, 1'b0, 8);
    spi_byte(8'h05, 1'b0, 1'b1, 1'b1, 8);
    cs_high();
    checks++;
    if (overflow !== 1'b0 || byte_count !== 16'd5) begin
      errors++;
      $display("FAIL full_pop_flags: overflow=%0b byte_count=%0d, required 0 and 5", overflow, byte_count);
    end
    rx_ready = 1'b1;
    wait_drain("full_pop");
  endtask

  initial begin
    wait_cyc(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_frame_error();
    test_idle_and_reset();
    test_full_with_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
Name: oled_spi_receiver

Overview:
SPI peripheral-side receiver for the OLED display link. It samples spi_cs, spi_clk, spi_mosi and oled_dc as driven by oled_controller, and reassembles each transfer into a byte tagged with its data/command flag. Bytes are delivered through a small FIFO with a valid/ready handshake. The block serves as the loopback/checker end of the display interface and as a display-side model for the SSD1306-style command stream.

Parameters:
SYNC_STAGES, 2, synchroniser depth on each SPI input (min 2)
FIFO_DEPTH, 4, receive FIFO entries (power of two, min 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
spi_cs  input  1  chip select, active low, asynchronous to clk
spi_clk  input  1  SPI clock, mode 0 (idle low, sample on rise), asynchronous
spi_mosi  input  1  serial data, MSB first
oled_dc  input  1  data/command select (1 = data, 0 = command)
rx_data  output  8  FIFO head byte
rx_dc  output  1  FIFO head D/C flag
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts head when high together with rx_valid
overflow  output  1  sticky: a byte was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse: CS released mid-byte
byte_count  output  16  count of bytes pushed into the FIFO, wraps at 0xFFFF -> 0

Behaviour:
- One clock (clk); reset is synchronous and active-high (port name reset). All state updates on rising clk.
- Reset values: synchroniser stages cs=1, clk=0, mosi=0, dc=0. Shift register 0; bit counter 0; FIFO empty. Outputs: rx_data=0, rx_dc=0, rx_valid=0, overflow=0, frame_err=0, byte_count=0.
- Synchronisation: each SPI input passes through SYNC_STAGES flops. Edge detection compares the last stage against one extra registered copy.
- Timing requirement on the SPI driver: SCLK high and low phases each last at least SYNC_STAGES+1 clk cycles. Behaviour for faster SCLK is unspecified.
- States: IDLE (sync cs high) and SHIFT (sync cs low).
  - IDLE->SHIFT on cs falling edge: bit counter cleared.
  - SHIFT->IDLE on cs rising edge.
- Bit capture: on each sync spi_clk rising edge while in SHIFT, shift in sync mosi (shift_reg <= {shift_reg[6:0], mosi}) and increment the 3-bit bit counter.
- Byte completion: on the rising edge that captures bit 8 (counter 7->0):
  - push {dc, byte} into the FIFO, where dc is the sync oled_dc value at that same edge;
  - byte_count increments.
- spi_clk edges while in IDLE are ignored entirely.
- CS rising edge with bit counter != 0: the partial byte is discarded, frame_err pulses high for exactly one cycle, and the counter clears. A CS rising edge with counter == 0 produces no pulse.
- Latency: rx_valid rises at the SYNC_STAGES-th clk edge after the clk edge that first samples raw spi_clk high for bit 8 (2 edges with defaults), provided the FIFO was empty.
- FIFO and handshake:
  - rx_data and rx_dc show the head entry while rx_valid=1; they hold the last-read values when the FIFO is empty.
  - Pop occurs on a cycle where rx_valid && rx_ready.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
- Full handling:
  - Push while full with no pop in the same cycle: the new byte is dropped, overflow is set and stays set until reset, and byte_count does not increment.
  - Push while full with a same-cycle pop: the push is accepted and overflow is not set.
- Reset mid-byte or mid-frame: all state returns to reset values and the FIFO is flushed. If raw cs is still low after reset, the first detected cs falling edge starts reception; bits clocked before that are ignored.

Test Plan:
1. One CS frame, byte 0x68 with oled_dc=1, rx_ready=1 -> one rx_valid cycle with rx_data=0x68, rx_dc=1; byte_count=1; frame_err and overflow stay 0.
2. A single frame carrying 0xAF (dc=0) then 0x65 (dc=1), with rx_ready held 0 until both are received -> FIFO delivers 0xAF/dc=0 then 0x65/dc=1 in order; byte_count=2.
3. rx_ready=0, send 5 bytes 0x01..0x05 -> overflow=1 after the 5th byte; byte_count=4; draining yields 0x01..0x04 only, then rx_valid=0.
4. CS released after 5 bits, then a new frame sends 0x6C -> one frame_err pulse and no push from the partial byte; 0x6C is received correctly; byte_count=1.
5. Toggle spi_clk 16 times with spi_cs high -> rx_valid stays 0 and byte_count stays 0. Then pulse reset for 1 cycle during the 4th bit of a frame -> all outputs return to 0; a following complete frame with 0x6F is received correctly.
6. FIFO full and a pop in the same cycle as the 5th byte's push -> the 5th byte is accepted, overflow stays 0, byte_count=5.
